// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU unified bus: imem fetch, dmem read/write via a posted
// write buffer with forwarding, image loader port. MMIO page enabled by MEM_RESP_MMIO_EN.
module cpu_mem_responder #(
  parameter int IMEM_AW  = 10,
  parameter int DMEM_AW  = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [31:0] mem_data,
  input  logic        read_mem_en,
  input  logic        write_mem_en,
  input  logic [31:0] memory_adr,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]        imem [2**IMEM_AW];
  logic [31:0]        dmem [2**DMEM_AW];
  logic [DMEM_AW-1:0] wb_word_reg [WB_DEPTH];
  logic [31:0]        wb_data_reg [WB_DEPTH];
  logic [PW-1:0]      wb_head_reg;
  logic [PW-1:0]      wb_tail_reg;
  logic [CW-1:0]      wb_count_reg;

  logic [IMEM_AW-1:0] cpu_iword;
  logic [DMEM_AW-1:0] cpu_dword;
  logic [IMEM_AW-1:0] ld_iword;
  logic [DMEM_AW-1:0] ld_dword;
  logic               is_mmio;
  logic               is_ram;
  logic               cpu_rd;
  logic               cpu_wr;
  logic               wb_empty;
  logic               wb_full;
  logic               enq;
  logic               drain;
  logic               fwd_hit;
  logic [31:0]        fwd_data;
  logic [PW-1:0]      fwd_slot;
  logic [31:0]        mmio_rd_data;
  logic [31:0]        rd_data;
  logic               unused_bits;

  assign cpu_iword = memory_adr[IMEM_AW+1:2];
  assign cpu_dword = memory_adr[DMEM_AW+1:2];
  assign ld_iword  = ld_addr[IMEM_AW+1:2];
  assign ld_dword  = ld_addr[DMEM_AW+1:2];

`ifdef MEM_RESP_MMIO_EN
  assign is_mmio = memory_adr[31] & memory_adr[30];
`else
  assign is_mmio = 1'b0;
`endif
  assign is_ram = memory_adr[31] & ~is_mmio;

  // Write strobe has priority; the bus is only ours on a pure read.
  assign cpu_wr = write_mem_en;
  assign cpu_rd = read_mem_en & ~write_mem_en;

  assign wb_empty = (wb_count_reg == '0);
  assign wb_full  = (wb_count_reg == CW'(WB_DEPTH));
  assign enq      = ~reset & cpu_wr & is_ram;
  assign drain    = ~reset & ~wb_empty & (wb_full | ~ld_valid);
  assign ld_ready = ld_valid & ~(~wb_empty & wb_full);

  // Scan oldest to newest so the newest matching entry is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_slot = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      fwd_slot = wb_head_reg + PW'(i);
      if ((CW'(i) < wb_count_reg) && (wb_word_reg[fwd_slot] == cpu_dword)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_reg[fwd_slot];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_ready) begin
      if (ld_addr[31])
        dmem[ld_dword] <= ld_data;
      else
        imem[ld_iword] <= ld_data;
    end
    if (drain)
      dmem[wb_word_reg[wb_head_reg]] <= wb_data_reg[wb_head_reg];
    if (enq) begin
      wb_word_reg[wb_tail_reg] <= cpu_dword;
      wb_data_reg[wb_tail_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_head_reg  <= '0;
      wb_tail_reg  <= '0;
      wb_count_reg <= '0;
    end else begin
      if (drain)
        wb_head_reg <= wb_head_reg + 1'b1;
      if (enq)
        wb_tail_reg <= wb_tail_reg + 1'b1;
      wb_count_reg <= wb_count_reg + CW'(enq) - CW'(drain);
    end
  end

`ifdef MEM_RESP_MMIO_EN
  logic [31:0] cycle_cnt_reg;
  logic        tx_valid_reg;
  logic [7:0]  tx_data_reg;
  logic        overrun_reg;
  logic        mmio_wr;
  logic        tx_wr;
  logic        status_wr;

  assign mmio_wr   = cpu_wr & is_mmio;
  assign tx_wr     = mmio_wr & (memory_adr[3:2] == 2'd0);
  assign status_wr = mmio_wr & (memory_adr[3:2] == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_reg <= '0;
      tx_valid_reg  <= 1'b0;
      tx_data_reg   <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (tx_valid_reg & tx_ready)
        tx_valid_reg <= 1'b0;
      // A byte leaving on this edge frees the slot for a write on the same edge.
      if (tx_wr) begin
        if (~tx_valid_reg | tx_ready) begin
          tx_data_reg  <= mem_data[7:0];
          tx_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end
      if (status_wr & mem_data[0])
        overrun_reg <= 1'b0;
    end
  end

  always_comb begin
    mmio_rd_data = '0;
    case (memory_adr[3:2])
      2'd0:    mmio_rd_data = {24'b0, tx_data_reg};
      2'd1:    mmio_rd_data = cycle_cnt_reg;
      2'd2:    mmio_rd_data = {30'b0, tx_valid_reg, overrun_reg};
      default: mmio_rd_data = '0;
    endcase
  end

  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
`else
  assign mmio_rd_data = '0;
  assign tx_valid     = 1'b0;
  assign tx_data      = '0;
`endif

  always_comb begin
    rd_data = '0;
    if (~memory_adr[31])
      rd_data = imem[cpu_iword];
    else if (is_mmio)
      rd_data = mmio_rd_data;
    else if (fwd_hit)
      rd_data = fwd_data;
    else
      rd_data = dmem[cpu_dword];
  end

  assign mem_data = cpu_rd ? rd_data : {32{1'bz}};

  // Aliased upper/low address bits and tx_ready (absent MMIO) are intentionally ignored.
  assign unused_bits = ^{memory_adr, ld_addr, tx_ready};

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder; read expectations go through a scoreboard queue.
// Optional MMIO checks compile in when MEM_RESP_MMIO_EN is defined.
module tb_cpu_mem_responder;

  logic        clk;
  logic        reset;
  wire  [31:0] mem_data;
  logic        read_mem_en;
  logic        write_mem_en;
  logic [31:0] memory_adr;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        cpu_oe;
  logic [31:0] cpu_wdata;

  int checks;
  int failures;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  assign mem_data = cpu_oe ? cpu_wdata : {32{1'bz}};

  cpu_mem_responder #(.IMEM_AW(10), .DMEM_AW(10), .WB_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .mem_data(mem_data),
    .read_mem_en(read_mem_en),
    .write_mem_en(write_mem_en),
    .memory_adr(memory_adr),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("check %-20s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    memory_adr  = a;
    read_mem_en = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    check(tag_q.pop_front(), mem_data, exp_q.pop_front());
    @(posedge clk); #1;
    read_mem_en = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic exp_rdy,
                           input string tag);
    memory_adr   = a;
    cpu_wdata    = d;
    cpu_oe       = 1'b1;
    write_mem_en = 1'b1;
    @(negedge clk);
    check(tag, {31'b0, ld_ready}, {31'b0, exp_rdy});
    @(posedge clk); #1;
    write_mem_en = 1'b0;
    cpu_oe       = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input string tag);
    ld_addr  = a;
    ld_data  = d;
    ld_valid = 1'b1;
    @(negedge clk);
    check(tag, {31'b0, ld_ready}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; read_mem_en = 1'b0; write_mem_en = 1'b0; memory_adr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; tx_ready = 1'b0;
    cpu_oe = 1'b0; cpu_wdata = '0;
    do_reset(2);

    // Reset state
    @(negedge clk);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    @(posedge clk); #1;

    // Loader fills imem, CPU fetches it back
    load(32'h0000_0000, 32'h11, "ld_imem0");
    load(32'h0000_0004, 32'h22, "ld_imem1");
    load(32'h0000_0008, 32'h33, "ld_imem2");
    load(32'h0000_000C, 32'h44, "ld_imem3");
    bus_read(32'h0000_0000, 32'h11, "fetch0");
    bus_read(32'h0000_0004, 32'h22, "fetch1");
    bus_read(32'h0000_0008, 32'h33, "fetch2");
    bus_read(32'h0000_000C, 32'h44, "fetch3");
    bus_read(32'h0000_0005, 32'h22, "fetch_lowbits");
    bus_read(32'h0000_1000, 32'h11, "fetch_alias");

    // CPU write into instruction space is dropped
    bus_write(32'h0000_0008, 32'hFFFF_FFFF, 1'b0, "imem_wr_rdy");
    bus_read(32'h0000_0008, 32'h33, "imem_wr_dropped");

    // Posted write forwarded next cycle, then visible from dmem
    load(32'h8000_0010, 32'h0, "ld_dmem4");
    bus_write(32'h8000_0010, 32'hDEAD_BEEF, 1'b0, "wr4_rdy");
    bus_read(32'h8000_0010, 32'hDEAD_BEEF, "fwd_word4");
    idle(2);
    bus_read(32'h8000_0010, 32'hDEAD_BEEF, "dmem_word4");
    bus_read(32'h8000_1010, 32'hDEAD_BEEF, "dmem_alias4");

    // Two pending writes to one word: newest wins, drain order preserved
    ld_addr = 32'h0000_0200; ld_data = 32'h0; ld_valid = 1'b1;
    bus_write(32'h8000_0020, 32'h1, 1'b1, "dup1_rdy");
    bus_write(32'h8000_0020, 32'h2, 1'b1, "dup2_rdy");
    bus_read(32'h8000_0020, 32'h2, "fwd_newest");
    ld_valid = 1'b0;
    idle(3);
    bus_read(32'h8000_0020, 32'h2, "drain_order");

    // Loader stream stalls once buffer fills; no CPU write lost
    ld_valid = 1'b1;
    for (int i = 0; i < 5; i++)
      bus_write(32'h8000_0100 + 32'(i * 4), 32'hC0 + 32'(i), (i < 4), $sformatf("stall_rdy%0d", i));
    @(negedge clk);
    check("stall_full_rdy", {31'b0, ld_ready}, 32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    idle(5);
    for (int i = 0; i < 5; i++)
      bus_read(32'h8000_0100 + 32'(i * 4), 32'hC0 + 32'(i), $sformatf("stall_data%0d", i));

    // Reset discards buffered writes and pending TX byte
    load(32'h8000_0040, 32'hA0, "ld_dmem16");
    load(32'h8000_0044, 32'hA1, "ld_dmem17");
    load(32'h8000_0048, 32'hA2, "ld_dmem18");
    ld_addr = 32'h0000_0200; ld_data = 32'h0; ld_valid = 1'b1;
    bus_write(32'h8000_0040, 32'hB0, 1'b1, "rstwr0_rdy");
    bus_write(32'h8000_0044, 32'hB1, 1'b1, "rstwr1_rdy");
    bus_write(32'h8000_0048, 32'hB2, 1'b1, "rstwr2_rdy");
    bus_read(32'h8000_0044, 32'hB1, "rst_pending_fwd");
`ifdef MEM_RESP_MMIO_EN
    bus_write(32'hC000_0000, 32'h55, 1'b1, "rst_tx_rdy");
`endif
    ld_valid = 1'b0;
    do_reset(1);
`ifdef MEM_RESP_MMIO_EN
    bus_read(32'hC000_0004, 32'd0, "cnt_after_rst");
    bus_read(32'hC000_0004, 32'd1, "cnt_next");
`endif
    @(negedge clk);
    check("rst2_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst2_tx_data", {24'b0, tx_data}, 32'd0);
    @(posedge clk); #1;
    bus_read(32'h8000_0040, 32'hA0, "rst_discard16");
    bus_read(32'h8000_0044, 32'hA1, "rst_discard17");
    bus_read(32'h8000_0048, 32'hA2, "rst_discard18");

`ifdef MEM_RESP_MMIO_EN
    // Console TX, overrun and status
    tx_ready = 1'b0;
    bus_write(32'hC000_0000, 32'h41, 1'b0, "tx41_rdy");
    check("tx_valid_set", {31'b0, tx_valid}, 32'd1);
    check("tx_data_41", {24'b0, tx_data}, 32'h41);
    bus_write(32'hC000_0000, 32'h42, 1'b0, "tx42_rdy");
    check("tx_data_kept", {24'b0, tx_data}, 32'h41);
    bus_read(32'hC000_0008, 32'h3, "status_overrun");
    bus_read(32'hC000_0000, 32'h41, "tx_reg_read");
    bus_read(32'hC000_000C, 32'h0, "mmio_reg3");
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("tx_valid_fall", {31'b0, tx_valid}, 32'd0);
    bus_write(32'hC000_0000, 32'h61, 1'b0, "tx61_rdy");
    tx_ready = 1'b1;
    bus_write(32'hC000_0000, 32'h62, 1'b0, "tx62_rdy");
    tx_ready = 1'b0;
    check("tx_hs_wr_valid", {31'b0, tx_valid}, 32'd1);
    check("tx_hs_wr_data", {24'b0, tx_data}, 32'h62);
    bus_write(32'hC000_0008, 32'h1, 1'b0, "clr_ovr_rdy");
    bus_read(32'hC000_0008, 32'h2, "status_cleared");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
